// File: rtl/max_net_pkg.sv
// -----------------------------------------------------------------------------
// max_net_pkg
// Shared definitions for the MAXNET winner-take-all block:
//   - default parameter values
//   - FSM state encoding
//   - clamp_to_zero(): forces a negative two's-complement value to zero
// -----------------------------------------------------------------------------
package max_net_pkg;

    localparam int unsigned DEFAULT_N        = 4;
    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_FRAC     = 12;
    localparam int unsigned DEFAULT_MAX_ITER = 63;

    // Widest activation the clamp helper can handle.
    localparam int unsigned CLAMP_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SUM    = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // The caller zero-extends a WIDTH-bit value into 'value' and names its
    // sign bit position; a set sign bit means the activation was negative.
    function automatic logic [CLAMP_MAX_W-1:0] clamp_to_zero(
        input logic [CLAMP_MAX_W-1:0] value,
        input logic [5:0]             sign_pos
    );
        logic [CLAMP_MAX_W-1:0] result;
        if (value[sign_pos]) begin
            result = '0;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage : max_net_pkg

// File: rtl/max_net_update_unit.sv
// -----------------------------------------------------------------------------
// max_net_update_unit
// Combinational inhibition step for one channel:
//   x_next = max(0, x_k - ceil(eps * (sum - x_k) / 2^FRAC))
// Ports:
//   x_k    : current (non-negative) activation of the channel
//   sum    : sum of all activations, frozen for the whole update phase
//   eps    : unsigned inhibition weight with FRAC fractional bits
//   x_next : updated activation
// -----------------------------------------------------------------------------
module max_net_update_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 12,
    parameter int unsigned SUM_W = 18
) (
    input  logic [WIDTH-1:0] x_k,
    input  logic [SUM_W-1:0] sum,
    input  logic [WIDTH-1:0] eps,
    output logic [WIDTH-1:0] x_next
);

    localparam int unsigned PROD_W = WIDTH + SUM_W;

    // Adding 2^FRAC-1 before the shift turns truncation into a ceiling, so
    // any nonzero product removes at least one LSB.
    localparam logic [PROD_W-1:0] ROUND_UP = {{(PROD_W-FRAC){1'b0}}, {FRAC{1'b1}}};

    logic [SUM_W-1:0]  others_s;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] dec_s;
    logic [PROD_W-1:0] x_wide_s;

    // Inhibition from the other channels, rounded up, then floored at zero.
    always_comb begin
        others_s = sum - {{(SUM_W-WIDTH){1'b0}}, x_k};
        prod_s   = {{SUM_W{1'b0}}, eps} * {{WIDTH{1'b0}}, others_s};
        dec_s    = (prod_s + ROUND_UP) >> FRAC;
        x_wide_s = {{SUM_W{1'b0}}, x_k};
        if (dec_s >= x_wide_s) begin
            x_next = '0;
        end else begin
            x_next = WIDTH'(x_wide_s - dec_s);
        end
    end

endmodule : max_net_update_unit

// File: rtl/max_net_n.sv
// -----------------------------------------------------------------------------
// max_net_n
// N-channel MAXNET winner-take-all. Activations mutually inhibit each other
// until a single nonzero channel remains (winner), all reach zero (tie), or
// the iteration cap is hit (timeout).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a competition (accepted only in IDLE or DONE)
//   x_init      : N packed signed activations, channel k at [k*WIDTH +: WIDTH]
//   eps         : unsigned inhibition weight, FRAC fractional bits
//   done        : high while in DONE
//   out         : one-hot winner, zero on tie or timeout
//   busy        : high in CHECK, SUM, UPDATE
//   tie         : every activation reached zero in the same iteration
//   timeout     : MAX_ITER iterations without a winner
//   iter_count  : completed iterations
// Each iteration is SUM (N cycles) then UPDATE (N cycles), one channel per
// cycle, followed by a single CHECK cycle. One update unit is time-shared.
// -----------------------------------------------------------------------------
module max_net_n
    import max_net_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned FRAC     = DEFAULT_FRAC,
    parameter int unsigned MAX_ITER = DEFAULT_MAX_ITER
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N*WIDTH-1:0]            x_init,
    input  logic [WIDTH-1:0]              eps,
    output logic                          done,
    output logic [N-1:0]                  out,
    output logic                          busy,
    output logic                          tie,
    output logic                          timeout,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int unsigned SUM_W  = WIDTH + $clog2(N);
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
    localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);
    localparam logic [N-1:0]      ONE_N    = {{(N-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    x_q [N];
    logic [WIDTH-1:0]    x_d [N];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [WIDTH-1:0]    eps_q, eps_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [N-1:0]        out_q, out_d;
    logic                tie_q, tie_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [WIDTH-1:0]    init_clamped_s [N];
    logic [N-1:0]        nz_s;
    logic                single_s;
    logic [WIDTH-1:0]    upd_s;

    max_net_update_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .SUM_W (SUM_W)
    ) u_update (
        .x_k    (x_q[idx_q]),
        .sum    (sum_q),
        .eps    (eps_q),
        .x_next (upd_s)
    );

    // Negative initial activations are clamped to zero at capture.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            init_clamped_s[k] = WIDTH'(clamp_to_zero(CLAMP_MAX_W'(x_init[k*WIDTH +: WIDTH]),
                                                     6'(WIDTH - 1)));
        end
    end

    // Nonzero map; exactly one bit set means a winner has emerged.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            nz_s[k] = (x_q[k] != '0);
        end
        single_s = (nz_s != '0) && ((nz_s & (nz_s - ONE_N)) == '0);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        sum_d     = sum_q;
        eps_d     = eps_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        out_d     = out_q;
        tie_d     = tie_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_d       = init_clamped_s;
                    eps_d     = eps;
                    iter_d    = '0;
                    out_d     = '0;
                    tie_d     = 1'b0;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_CHECK;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_CHECK: begin
                if (single_s) begin
                    out_d   = nz_s;
                    state_d = ST_DONE;
                end else if (nz_s == '0) begin
                    tie_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (iter_q == ITER_CAP) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    iter_d  = iter_q + ITER_W'(1);
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SUM;
                end
            end
            ST_SUM: begin
                sum_d = sum_q + {{(SUM_W-WIDTH){1'b0}}, x_q[idx_q]};
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_UPDATE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_UPDATE: begin
                // Only channel idx_q changes, so sum_q stays the pre-update sum.
                x_d[idx_q] = upd_s;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_CHECK) || (state_d == ST_SUM) || (state_d == ST_UPDATE);
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
            end
            sum_q     <= '0;
            eps_q     <= '0;
            idx_q     <= '0;
            iter_q    <= '0;
            out_q     <= '0;
            tie_q     <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            sum_q     <= sum_d;
            eps_q     <= eps_d;
            idx_q     <= idx_d;
            iter_q    <= iter_d;
            out_q     <= out_d;
            tie_q     <= tie_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign done       = done_q;
    assign out        = out_q;
    assign busy       = busy_q;
    assign tie        = tie_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_q;

endmodule : max_net_n

// File: tb/tb_max_net_n.sv
// -----------------------------------------------------------------------------
// tb_max_net_n
// Directed bench for max_net_n. dut_a uses default parameters, dut_b uses
// MAX_ITER=3 to reach the timeout path. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_max_net_n;

    localparam logic [63:0] X_WIN   = {16'h0CCD, 16'h099A, 16'h0666, 16'h0333};
    localparam logic [63:0] X_TIE   = {16'h0800, 16'h0800, 16'h0800, 16'h0800};
    localparam logic [63:0] X_CLAMP = {16'hF000, 16'h0800, 16'h0000, 16'h0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [63:0] x_init;
    logic [15:0] eps;

    logic        done_a, busy_a, tie_a, timeout_a;
    logic [3:0]  out_a;
    logic [5:0]  iter_a;
    logic        done_b, busy_b, tie_b, timeout_b;
    logic [3:0]  out_b;
    logic [1:0]  iter_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    max_net_n #(.N(4), .WIDTH(16), .FRAC(12), .MAX_ITER(63)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .x_init(x_init), .eps(eps),
        .done(done_a), .out(out_a), .busy(busy_a), .tie(tie_a),
        .timeout(timeout_a), .iter_count(iter_a)
    );

    max_net_n #(.N(4), .WIDTH(16), .FRAC(12), .MAX_ITER(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .x_init(x_init), .eps(eps),
        .done(done_b), .out(out_b), .busy(busy_b), .tie(tie_b),
        .timeout(timeout_b), .iter_count(iter_b)
    );

    // Launch one competition and count edges from the capture edge to done.
    task automatic run_dut(input bit use_b, input logic [63:0] xv,
                           input logic [15:0] ev, output int edges);
        @(negedge clk);
        x_init = xv;
        eps    = ev;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if ((use_b && done_b) || (!use_b && done_a)) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; x_init = '0; eps = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done_a, out_a, busy_a, tie_a, timeout_a, iter_a} !== 14'h0) begin
            failures++;
            $display("FAIL reset_a: got %h expected 0", {done_a, out_a, busy_a, tie_a, timeout_a, iter_a});
        end
        checks++;
        if ({done_b, out_b, busy_b, tie_b, timeout_b, iter_b} !== 10'h0) begin
            failures++;
            $display("FAIL reset_b: got %h expected 0", {done_b, out_b, busy_b, tie_b, timeout_b, iter_b});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_wait: done=%b busy=%b expected 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_winner();
        int edges;
        run_dut(1'b0, X_WIN, 16'h0333, edges);
        checks++;
        if (edges !== 46) begin failures++; $display("FAIL winner_latency: got %0d expected 46", edges); end
        checks++;
        if (out_a !== 4'b1000) begin failures++; $display("FAIL winner_out: got %b expected 1000", out_a); end
        checks++;
        if (iter_a !== 6'd5) begin failures++; $display("FAIL winner_iter: got %0d expected 5", iter_a); end
        checks++;
        if (tie_a !== 1'b0 || timeout_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL winner_flags: tie=%b timeout=%b busy=%b expected 0 0 0", tie_a, timeout_a, busy_a);
        end
        // Results hold in DONE.
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_a !== 1'b1 || out_a !== 4'b1000 || iter_a !== 6'd5) begin
            failures++;
            $display("FAIL done_hold: done=%b out=%b iter=%0d expected 1 1000 5", done_a, out_a, iter_a);
        end
    endtask

    task automatic test_tie();
        int edges;
        run_dut(1'b0, X_TIE, 16'h0800, edges);
        checks++;
        if (edges !== 10) begin failures++; $display("FAIL tie_latency: got %0d expected 10", edges); end
        checks++;
        if (tie_a !== 1'b1 || out_a !== 4'b0000) begin
            failures++;
            $display("FAIL tie_result: tie=%b out=%b expected 1 0000", tie_a, out_a);
        end
        checks++;
        if (iter_a !== 6'd1) begin failures++; $display("FAIL tie_iter: got %0d expected 1", iter_a); end
    endtask

    task automatic test_clamp();
        int edges;
        run_dut(1'b0, X_CLAMP, 16'h0333, edges);
        checks++;
        if (edges !== 1) begin failures++; $display("FAIL clamp_latency: got %0d expected 1", edges); end
        checks++;
        if (out_a !== 4'b0100 || tie_a !== 1'b0) begin
            failures++;
            $display("FAIL clamp_out: out=%b tie=%b expected 0100 0", out_a, tie_a);
        end
        checks++;
        if (iter_a !== 6'd0) begin failures++; $display("FAIL clamp_iter: got %0d expected 0", iter_a); end
    endtask

    task automatic test_timeout();
        int edges;
        run_dut(1'b1, X_WIN, 16'h0333, edges);
        checks++;
        if (edges !== 28) begin failures++; $display("FAIL timeout_latency: got %0d expected 28", edges); end
        checks++;
        if (timeout_b !== 1'b1 || out_b !== 4'b0000 || tie_b !== 1'b0) begin
            failures++;
            $display("FAIL timeout_result: timeout=%b out=%b tie=%b expected 1 0000 0", timeout_b, out_b, tie_b);
        end
        checks++;
        if (iter_b !== 2'd3) begin failures++; $display("FAIL timeout_iter: got %0d expected 3", iter_b); end
    endtask

    task automatic test_start_ignored();
        int edges;
        @(negedge clk);
        x_init = X_WIN; eps = 16'h0333; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        edges = 0;
        while (edges < 200 && !done_a) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 3) begin
                start_a = 1'b1;       // lands during SUM
                x_init  = X_CLAMP;
            end else if (edges == 4) begin
                start_a = 1'b0;
            end
        end
        checks++;
        if (edges !== 46) begin failures++; $display("FAIL ignore_latency: got %0d expected 46", edges); end
        checks++;
        if (out_a !== 4'b1000 || iter_a !== 6'd5) begin
            failures++;
            $display("FAIL ignore_result: out=%b iter=%0d expected 1000 5", out_a, iter_a);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        @(negedge clk);
        x_init = X_WIN; eps = 16'h0333; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);   // now in UPDATE of the first iteration
        #1;
        checks++;
        if (busy_a !== 1'b1 || iter_a !== 6'd1) begin
            failures++;
            $display("FAIL mid_busy: busy=%b iter=%0d expected 1 1", busy_a, iter_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({done_a, out_a, busy_a, tie_a, timeout_a, iter_a} !== 14'h0) begin
            failures++;
            $display("FAIL mid_reset: got %h expected 0", {done_a, out_a, busy_a, tie_a, timeout_a, iter_a});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle: done=%b busy=%b expected 0 0", done_a, busy_a);
        end
        run_dut(1'b0, X_CLAMP, 16'h0333, edges);
        checks++;
        if (edges !== 1 || out_a !== 4'b0100) begin
            failures++;
            $display("FAIL mid_restart: edges=%0d out=%b expected 1 0100", edges, out_a);
        end
    endtask

    initial begin
        test_reset();
        test_winner();
        test_tie();
        test_clamp();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_max_net_n
